// File: rtl/rr_arbiter4_pkg.sv
// Shared types and constants for the four-way round-robin arbiter.
package arb_pkg;

   localparam int ARB_PORTS = 4;

   // S_IDLE: nothing offered downstream; S_GRANT: switch is presented with out_valid.
   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } arb_state_t;

   // One-hot decode of a requester index.
   function automatic logic [ARB_PORTS-1:0] onehot4(input logic [1:0] idx);
      logic [ARB_PORTS-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant handshake bundle between the arbiter and its requesters/consumer.
interface rr_arbiter4_if;
   import arb_pkg::*;

   logic [ARB_PORTS-1:0] req;
   logic [1:0]           switch;
   logic                 out_valid;
   logic                 out_ready;
   logic [ARB_PORTS-1:0] ack;
   logic                 timeout;

   // Arbiter side.
   modport master (
      input  req,
      input  out_ready,
      output switch,
      output out_valid,
      output ack,
      output timeout
   );

   // Requester / consumer side.
   modport slave (
      output req,
      output out_ready,
      input  switch,
      input  out_valid,
      input  ack,
      input  timeout
   );
endinterface

// File: rtl/rr_arbiter4_pick.sv
// Rotating priority picker: first set bit of mask searching start, start+1, ... mod 4.
module rr_pick4
   import arb_pkg::*;
(
   input  logic [ARB_PORTS-1:0] mask,
   input  logic [1:0]           start,
   output logic                 any,
   output logic [1:0]           idx
);

   logic [1:0]           cand [ARB_PORTS];
   logic [ARB_PORTS-1:0] rot;
   logic [1:0]           off;

   // rot[k] is the request of the requester k positions after start.
   for (genvar gi = 0; gi < ARB_PORTS; gi++) begin : g_rot
      localparam logic [1:0] OFF = 2'(gi);
      assign cand[gi] = start + OFF;
      assign rot[gi]  = mask[cand[gi]];
   end

   // Lowest rotated position wins; idx is only meaningful when any is high.
   always_comb begin
      off = 2'd0;
      if (rot[0])      off = 2'd0;
      else if (rot[1]) off = 2'd1;
      else if (rot[2]) off = 2'd2;
      else if (rot[3]) off = 2'd3;
   end

   assign any = |mask;
   assign idx = start + off;

endmodule

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter producing the 4:1 mux select with a valid/ready
// handshake and a watchdog that drops grants the consumer stalls on.
module rr_arbiter4
   import arb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
)(
   input  logic          clk,
   input  logic          rst,
   rr_arbiter4_if.master bus
);

   localparam int unsigned       CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
   localparam bit                WD_EN    = (TIMEOUT > 0);

   arb_state_t         state_q, state_d;
   logic [1:0]         ptr_q, ptr_d;
   logic [1:0]         switch_q, switch_d;
   logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic               timeout_q, timeout_d;

   logic               idle_any, next_any;
   logic [1:0]         idle_idx, next_idx;
   logic [1:0]         switch_inc;
   logic [ARB_PORTS-1:0] next_mask;
   logic               out_valid;

   assign switch_inc = switch_q + 2'd1;
   // The current winner is excluded so it only regains the bus after the others.
   assign next_mask  = bus.req & ~onehot4(switch_q);

   rr_pick4 u_pick_idle (
      .mask  (bus.req),
      .start (ptr_q),
      .any   (idle_any),
      .idx   (idle_idx)
   );

   rr_pick4 u_pick_next (
      .mask  (next_mask),
      .start (switch_inc),
      .any   (next_any),
      .idx   (next_idx)
   );

   // Next-state: grant from idle, or transfer / withdraw / timeout / wait while granted.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      switch_d   = switch_q;
      wait_cnt_d = wait_cnt_q;
      timeout_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (idle_any) begin
               switch_d   = idle_idx;
               wait_cnt_d = '0;
               state_d    = S_GRANT;
            end
         end
         S_GRANT: begin
            if (bus.out_ready) begin
               ptr_d = switch_inc;
               if (next_any) begin
                  switch_d   = next_idx;
                  wait_cnt_d = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (!bus.req[switch_q]) begin
               ptr_d   = switch_inc;
               state_d = S_IDLE;
            end else if (WD_EN && (wait_cnt_q == CNT_LAST)) begin
               timeout_d = 1'b1;
               ptr_d     = switch_inc;
               state_d   = S_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers with synchronous reset; reset mid-grant drops the grant silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ptr_q      <= 2'd0;
         switch_q   <= 2'd0;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         switch_q   <= switch_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign out_valid     = (state_q == S_GRANT);
   assign bus.out_valid = out_valid;
   assign bus.switch    = switch_q;
   assign bus.timeout   = timeout_q;
   assign bus.ack       = (out_valid && bus.out_ready) ? onehot4(switch_q) : '0;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench: directed vector table, hand sequences, randomized model check.
module tb_rr_arbiter4;
   import arb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rr_arbiter4_if ifa ();
   rr_arbiter4_if ifb ();

   rr_arbiter4 #(.TIMEOUT(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
   rr_arbiter4 #(.TIMEOUT(4))  dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       rdy;
      logic       v;
      logic [1:0] sw;
      logic [3:0] ack;
      logic       to;
   } vec_t;

   typedef struct {
      bit busy;
      int sw;
      int ptr;
      int waitc;
      bit to;
   } mdl_t;

   vec_t vecs [21];

   function automatic vec_t mk(logic r, logic [3:0] q, logic rd, logic v, logic [1:0] sw,
                               logic [3:0] ak, logic to);
      vec_t x;
      x.rst = r; x.req = q; x.rdy = rd; x.v = v; x.sw = sw; x.ack = ak; x.to = to;
      return x;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [3:0] q, input logic rd);
      rst = r;
      ifa.req = q;       ifb.req = q;
      ifa.out_ready = rd; ifb.out_ready = rd;
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Reference: first requester at or after start (mod 4).
   function automatic int pick(input logic [3:0] m, input int start);
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (start + k) % 4;
         if (m[i]) return i;
      end
      return -1;
   endfunction

   function automatic mdl_t step(input mdl_t m, input logic r, input logic [3:0] q,
                                 input logic rd, input int tmo);
      mdl_t n;
      logic [3:0] rest;
      n = m;
      n.to = 1'b0;
      if (r) begin
         n.busy = 0; n.sw = 0; n.ptr = 0; n.waitc = 0;
      end else if (!m.busy) begin
         if (q != 4'd0) begin
            n.sw = pick(q, m.ptr); n.busy = 1; n.waitc = 0;
         end
      end else if (rd) begin
         n.ptr = (m.sw + 1) % 4;
         rest = q;
         rest[m.sw] = 1'b0;
         if (rest != 4'd0) begin
            n.sw = pick(rest, n.ptr); n.waitc = 0;
         end else begin
            n.busy = 0;
         end
      end else if (!q[m.sw]) begin
         n.ptr = (m.sw + 1) % 4; n.busy = 0;
      end else if (tmo > 0 && m.waitc == tmo - 1) begin
         n.to = 1'b1; n.ptr = (m.sw + 1) % 4; n.busy = 0;
      end else begin
         n.waitc = m.waitc + 1;
      end
      return n;
   endfunction

   function automatic int exp_ack(input mdl_t m, input logic rd);
      return (m.busy && rd) ? (1 << m.sw) : 0;
   endfunction

   initial begin
      mdl_t ma, mb;
      logic [3:0] q;
      logic rd, r;
      int rdy_pct;

      // Reset, full contention, sparse rotation, backpressure (checked on TIMEOUT=16 instance).
      vecs[0]  = mk(1, 4'hF, 1, 0, 2'd0, 4'h0, 0);
      vecs[1]  = mk(0, 4'hF, 1, 0, 2'd0, 4'h0, 0);
      vecs[2]  = mk(0, 4'hF, 1, 1, 2'd0, 4'h1, 0);
      vecs[3]  = mk(0, 4'hF, 1, 1, 2'd1, 4'h2, 0);
      vecs[4]  = mk(0, 4'hF, 1, 1, 2'd2, 4'h4, 0);
      vecs[5]  = mk(0, 4'hF, 1, 1, 2'd3, 4'h8, 0);
      vecs[6]  = mk(0, 4'hF, 1, 1, 2'd0, 4'h1, 0);
      vecs[7]  = mk(1, 4'hA, 0, 1, 2'd1, 4'h0, 0);
      vecs[8]  = mk(0, 4'hA, 1, 0, 2'd0, 4'h0, 0);
      vecs[9]  = mk(0, 4'hA, 1, 1, 2'd1, 4'h2, 0);
      vecs[10] = mk(0, 4'hA, 1, 1, 2'd3, 4'h8, 0);
      vecs[11] = mk(0, 4'hA, 1, 1, 2'd1, 4'h2, 0);
      vecs[12] = mk(1, 4'hA, 0, 1, 2'd3, 4'h0, 0);
      vecs[13] = mk(0, 4'h4, 0, 0, 2'd0, 4'h0, 0);
      for (int i = 14; i <= 18; i++) vecs[i] = mk(0, 4'h4, 0, 1, 2'd2, 4'h0, 0);
      vecs[19] = mk(0, 4'h4, 1, 1, 2'd2, 4'h4, 0);
      vecs[20] = mk(0, 4'h0, 1, 0, 2'd2, 4'h0, 0);

      drive(1, 4'hF, 1);
      tick(); tick();

      for (int i = 0; i < 21; i++) begin
         drive(vecs[i].rst, vecs[i].req, vecs[i].rdy);
         #1;
         $display("vec %0d req=%b rdy=%0d -> valid=%0d switch=%0d ack=%b timeout=%0d",
                  i, vecs[i].req, vecs[i].rdy, ifa.out_valid, ifa.switch, ifa.ack, ifa.timeout);
         chk($sformatf("vec%0d_valid", i), int'(ifa.out_valid), int'(vecs[i].v));
         chk($sformatf("vec%0d_switch", i), int'(ifa.switch), int'(vecs[i].sw));
         chk($sformatf("vec%0d_ack", i), int'(ifa.ack), int'(vecs[i].ack));
         chk($sformatf("vec%0d_timeout", i), int'(ifa.timeout), int'(vecs[i].to));
         tick();
      end

      // Watchdog on the TIMEOUT=4 instance: req=0001, consumer never ready.
      drive(1, 4'h1, 0); tick();
      drive(0, 4'h1, 0); #1;
      chk("wd_idle_valid", int'(ifb.out_valid), 0);
      tick();
      for (int k = 1; k <= 4; k++) begin
         #1;
         chk($sformatf("wd_c%0d_valid", k), int'(ifb.out_valid), 1);
         chk($sformatf("wd_c%0d_timeout", k), int'(ifb.timeout), 0);
         tick();
      end
      #1;
      $display("watchdog pulse: valid=%0d timeout=%0d", ifb.out_valid, ifb.timeout);
      chk("wd_c5_valid", int'(ifb.out_valid), 0);
      chk("wd_c5_timeout", int'(ifb.timeout), 1);
      chk("wd_c5_a_valid", int'(ifa.out_valid), 1);
      tick(); #1;
      chk("wd_c6_valid", int'(ifb.out_valid), 1);
      chk("wd_c6_switch", int'(ifb.switch), 0);
      chk("wd_c6_timeout", int'(ifb.timeout), 0);
      tick();

      // Withdraw on the TIMEOUT=16 instance: grant 3, drop req[3] with req[0] high.
      drive(1, 4'h8, 0); tick();
      drive(0, 4'h8, 0); tick();
      #1;
      chk("wd3_grant_valid", int'(ifa.out_valid), 1);
      chk("wd3_grant_switch", int'(ifa.switch), 3);
      tick();
      drive(0, 4'h1, 0); #1;
      chk("wd3_drop_ack", int'(ifa.ack), 0);
      tick(); #1;
      chk("wd3_idle_valid", int'(ifa.out_valid), 0);
      chk("wd3_idle_ack", int'(ifa.ack), 0);
      tick(); #1;
      $display("withdraw regrant: valid=%0d switch=%0d", ifa.out_valid, ifa.switch);
      chk("wd3_regrant_valid", int'(ifa.out_valid), 1);
      chk("wd3_regrant_switch", int'(ifa.switch), 0);
      tick();

      // Randomized run on both instances against the reference model.
      drive(1, 4'h0, 0); tick();
      ma = '{busy: 0, sw: 0, ptr: 0, waitc: 0, to: 0};
      mb = ma;
      q = 4'h0;
      for (int cyc = 0; cyc < 1200; cyc++) begin
         rdy_pct = ((cyc / 150) % 2 != 0) ? 20 : 70;
         if ($urandom_range(0, 3) == 0) q = 4'($urandom_range(0, 15));
         rd = ($urandom_range(0, 99) < rdy_pct);
         r  = ($urandom_range(0, 199) == 0);
         drive(r, q, rd);
         #1;
         chk("rnd_a_valid", int'(ifa.out_valid), int'(ma.busy));
         chk("rnd_a_switch", int'(ifa.switch), ma.sw);
         chk("rnd_a_ack", int'(ifa.ack), exp_ack(ma, rd));
         chk("rnd_a_timeout", int'(ifa.timeout), int'(ma.to));
         chk("rnd_b_valid", int'(ifb.out_valid), int'(mb.busy));
         chk("rnd_b_switch", int'(ifb.switch), mb.sw);
         chk("rnd_b_ack", int'(ifb.ack), exp_ack(mb, rd));
         chk("rnd_b_timeout", int'(ifb.timeout), int'(mb.to));
         if (mb.busy && rd)
            $display("rnd %0d transfer b switch=%0d", cyc, mb.sw);
         ma = step(ma, r, q, rd, 16);
         mb = step(mb, r, q, rd, 4);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
